id_stage: RTL and testbench

RV32I decode stage that sits directly upstream of the register file and downstream of IF/ID.
- Decodes the instruction held in IF/ID and drives the regfile read ports.
- Resolves operands with forwarding from EX and MEM.
- Detects load-use hazards and raises a stall.
- Holds the ID/EX pipeline register, with stall, bubble and flush handling.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/imm_gen.sv | 25 ++
 rtl/id_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_id_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - base opcode constants (inst[6:0])
//   - ALU operation encoding, ALU_NOP = 0 so an all-zero ID/EX entry is a bubble
//   - ZeroWord / Enable / Disable helpers
//   - funct3 -> ALU op helpers for the arithmetic and branch groups
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLL  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_OR   = 5'd9,
        ALU_AND  = 5'd10,
        ALU_BEQ  = 5'd11,
        ALU_BNE  = 5'd12,
        ALU_BLT  = 5'd13,
        ALU_BGE  = 5'd14,
        ALU_BLTU = 5'd15,
        ALU_BGEU = 5'd16
    } alu_op_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e branch_decode(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   inst  : instruction word
//   imm_i : I-type, sign-extended
//   imm_s : S-type, sign-extended
//   imm_b : B-type, sign-extended, bit 0 = 0
//   imm_u : U-type, low 12 bits = 0
//   imm_j : J-type, sign-extended, bit 0 = 0
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage and ID/EX pipeline register.
//   dclk, rst            : clock, synchronous active-high reset
//   stall_i, flush_i     : MEM-busy hold of ID/EX; kill of the ID instruction
//   id_valid_i/pc/inst   : IF/ID contents
//   re*/raddr*/rdata*    : regfile read ports (regfile bypasses WB itself)
//   fex_* / fmem_*       : EX and MEM results for forwarding / hazard checks
//   stall_req_o          : hold request to IF and IF/ID
//   ex_*                 : ID/EX register contents
// Build option: ID_FORWARD_EN enables EX/MEM operand forwarding (load-use is
// then the only hazard). Without it operands come straight from the regfile
// and any pending EX/MEM producer of an enabled source stalls the stage.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               dclk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [31:0]        id_inst_i,
    output logic               re1_o,
    output logic [4:0]         raddr1_o,
    input  logic [XLEN-1:0]    rdata1_i,
    output logic               re2_o,
    output logic [4:0]         raddr2_o,
    input  logic [XLEN-1:0]    rdata2_i,
    input  logic               fex_we_i,
    input  logic [4:0]         fex_waddr_i,
    input  logic [XLEN-1:0]    fex_wdata_i,
    input  logic               fex_load_i,
    input  logic               fmem_we_i,
    input  logic [4:0]         fmem_waddr_i,
    input  logic [XLEN-1:0]    fmem_wdata_i,
    output logic               stall_req_o,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [XLEN-1:0]    ex_op1_o,
    output logic [XLEN-1:0]    ex_op2_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_we_o,
    output logic               ex_load_o,
    output logic               ex_store_o,
    output logic               ex_branch_o
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [ALUOP_W-1:0] aluop;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [XLEN-1:0]    imm;
        logic [4:0]         rd;
        logic               we;
        logic               load;
        logic               store;
        logic               branch;
    } id_ex_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    assign opcode = id_inst_i[6:0];
    assign funct3 = id_inst_i[14:12];
    assign rs1    = id_inst_i[19:15];
    assign rs2    = id_inst_i[24:20];
    assign rd     = id_inst_i[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (id_inst_i),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    logic            legal, uses_rs1, uses_rs2;
    logic            dec_we, dec_load, dec_store, dec_branch;
    alu_op_e         dec_aluop;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        legal      = Disable;
        uses_rs1   = Disable;
        uses_rs2   = Disable;
        dec_we     = Disable;
        dec_load   = Disable;
        dec_store  = Disable;
        dec_branch = Disable;
        dec_aluop  = ALU_NOP;
        dec_imm    = XLEN'(ZeroWord);
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                legal = Enable; dec_we = Enable;
                dec_aluop = ALU_ADD; dec_imm = imm_u;
            end
            OP_JAL: begin
                legal = Enable; dec_we = Enable; dec_branch = Enable;
                dec_aluop = ALU_ADD; dec_imm = imm_j;
            end
            OP_JALR: begin
                legal = Enable; uses_rs1 = Enable; dec_we = Enable; dec_branch = Enable;
                dec_aluop = ALU_ADD; dec_imm = imm_i;
            end
            OP_BRANCH: begin
                legal = Enable; uses_rs1 = Enable; uses_rs2 = Enable; dec_branch = Enable;
                dec_aluop = branch_decode(funct3); dec_imm = imm_b;
            end
            OP_LOAD: begin
                legal = Enable; uses_rs1 = Enable; dec_we = Enable; dec_load = Enable;
                dec_aluop = ALU_ADD; dec_imm = imm_i;
            end
            OP_STORE: begin
                legal = Enable; uses_rs1 = Enable; uses_rs2 = Enable; dec_store = Enable;
                dec_aluop = ALU_ADD; dec_imm = imm_s;
            end
            OP_IMM: begin
                legal = Enable; uses_rs1 = Enable; dec_we = Enable;
                // bit 30 is an immediate bit for ADDI; only SRAI uses it as a selector
                dec_aluop = alu_decode(funct3, id_inst_i[30] && (funct3 == 3'b101));
                dec_imm = imm_i;
            end
            OP_REG: begin
                legal = Enable; uses_rs1 = Enable; uses_rs2 = Enable; dec_we = Enable;
                dec_aluop = alu_decode(funct3, id_inst_i[30]);
            end
            default: ;
        endcase
    end

    assign re1_o    = id_valid_i && uses_rs1;
    assign re2_o    = id_valid_i && uses_rs2;
    assign raddr1_o = rs1;
    assign raddr2_o = rs2;

    // EX destination matches an enabled source (rd = x0 never matches)
    logic ex_hit;
    assign ex_hit = fex_we_i && (fex_waddr_i != 5'd0) &&
                    ((re1_o && (fex_waddr_i == rs1)) || (re2_o && (fex_waddr_i == rs2)));

    logic [XLEN-1:0] src1, src2;
    logic            hazard;

`ifdef ID_FORWARD_EN
    // Youngest producer wins: EX before MEM before the regfile.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rdata,
        input logic            ex_we,
        input logic [4:0]      ex_wa,
        input logic [XLEN-1:0] ex_wd,
        input logic            mem_we,
        input logic [4:0]      mem_wa,
        input logic [XLEN-1:0] mem_wd
    );
        if (rs == 5'd0)                return '0;
        else if (ex_we && ex_wa == rs)   return ex_wd;
        else if (mem_we && mem_wa == rs) return mem_wd;
        else                             return rdata;
    endfunction

    assign src1 = resolve(rs1, rdata1_i, fex_we_i, fex_waddr_i, fex_wdata_i,
                          fmem_we_i, fmem_waddr_i, fmem_wdata_i);
    assign src2 = resolve(rs2, rdata2_i, fex_we_i, fex_waddr_i, fex_wdata_i,
                          fmem_we_i, fmem_waddr_i, fmem_wdata_i);
    // only a load in EX has no value yet; one bubble lets it reach MEM
    assign hazard = ex_hit && fex_load_i;
`else
    logic mem_hit;
    assign mem_hit = fmem_we_i && (fmem_waddr_i != 5'd0) &&
                     ((re1_o && (fmem_waddr_i == rs1)) || (re2_o && (fmem_waddr_i == rs2)));
    assign src1   = rdata1_i;
    assign src2   = rdata2_i;
    // bubble until the producer has left MEM and the regfile bypass covers it
    assign hazard = ex_hit || mem_hit;

    logic unused_fwd;
    assign unused_fwd = ^{fex_wdata_i, fmem_wdata_i, fex_load_i};
`endif

    logic [XLEN-1:0] sel_op1, sel_op2;

    always_comb begin
        sel_op1 = src1;
        sel_op2 = src2;
        case (opcode)
            OP_LUI:                    begin sel_op1 = '0;      sel_op2 = dec_imm;    end
            OP_AUIPC:                  begin sel_op1 = id_pc_i; sel_op2 = dec_imm;    end
            OP_JAL, OP_JALR:           begin sel_op1 = id_pc_i; sel_op2 = XLEN'(4);   end
            OP_LOAD, OP_STORE, OP_IMM: sel_op2 = dec_imm;
            default: ;
        endcase
    end

    assign stall_req_o = !rst && !flush_i && (stall_i || hazard);

    id_ex_t dec, ex_q;

    always_comb begin
        dec        = '0;
        dec.valid  = Enable;
        dec.pc     = id_pc_i;
        dec.aluop  = ALUOP_W'(dec_aluop);
        dec.op1    = sel_op1;
        dec.op2    = sel_op2;
        dec.imm    = dec_imm;
        dec.rd     = rd;
        dec.we     = dec_we;
        dec.load   = dec_load;
        dec.store  = dec_store;
        dec.branch = dec_branch;
    end

    // A bubble is the all-zero entry (ALU_NOP, no side effects).
    always_ff @(posedge dclk) begin
        if (rst)                         ex_q <= '0;
        else if (flush_i)                ex_q <= '0;
        else if (stall_i)                ex_q <= ex_q;
        else if (hazard)                 ex_q <= '0;
        else if (id_valid_i && legal)    ex_q <= dec;
        else                             ex_q <= '0;
    end

    assign ex_valid_o  = ex_q.valid;
    assign ex_pc_o     = ex_q.pc;
    assign ex_aluop_o  = ex_q.aluop;
    assign ex_op1_o    = ex_q.op1;
    assign ex_op2_o    = ex_q.op2;
    assign ex_imm_o    = ex_q.imm;
    assign ex_rd_o     = ex_q.rd;
    assign ex_we_o     = ex_q.we;
    assign ex_load_o   = ex_q.load;
    assign ex_store_o  = ex_q.store;
    assign ex_branch_o = ex_q.branch;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage with a behavioural
// decode/forward/hazard reference model and randomized stimulus.
module tb_id_stage;
    import riscv_pkg::*;

    logic        dclk = 1'b0;
    logic        rst, stall_i, flush_i, id_valid_i;
    logic [31:0] id_pc_i, id_inst_i;
    logic        re1_o, re2_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic        fex_we_i, fex_load_i, fmem_we_i;
    logic [4:0]  fex_waddr_i, fmem_waddr_i;
    logic [31:0] fex_wdata_i, fmem_wdata_i;
    logic        stall_req_o, ex_valid_o, ex_we_o, ex_load_o, ex_store_o, ex_branch_o;
    logic [31:0] ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o;
    logic [4:0]  ex_aluop_o, ex_rd_o;

    id_stage #(.XLEN(32), .ALUOP_W(5)) dut (
        .dclk(dclk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_inst_i(id_inst_i),
        .re1_o(re1_o), .raddr1_o(raddr1_o), .rdata1_i(rdata1_i),
        .re2_o(re2_o), .raddr2_o(raddr2_o), .rdata2_i(rdata2_i),
        .fex_we_i(fex_we_i), .fex_waddr_i(fex_waddr_i), .fex_wdata_i(fex_wdata_i),
        .fex_load_i(fex_load_i), .fmem_we_i(fmem_we_i), .fmem_waddr_i(fmem_waddr_i),
        .fmem_wdata_i(fmem_wdata_i), .stall_req_o(stall_req_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_imm_o(ex_imm_o),
        .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_load_o(ex_load_o),
        .ex_store_o(ex_store_o), .ex_branch_o(ex_branch_o)
    );

    always #5 dclk = ~dclk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  aluop;
        logic [31:0] op1, op2, imm;
        logic [4:0]  rd;
        logic        we, load, store, branch;
    } ex_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] regs [32];
    ex_t  exp_ex  = '0;
    ex_t  exp_nxt = '0;
    logic exp_sreq, exp_re1, exp_re2;

    alu_op_e alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_e br_tab  [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X3_1_2 = 32'h0020_81B3;

    function automatic ex_t dut_ex();
        return {ex_valid_o, ex_pc_o, ex_aluop_o, ex_op1_o, ex_op2_o, ex_imm_o,
                ex_rd_o, ex_we_o, ex_load_o, ex_store_o, ex_branch_o};
    endfunction

    // immediates by arithmetic on the signed word
    function automatic logic [31:0] imm_of(input logic [31:0] w, input byte kind);
        logic signed [31:0] s = $signed(w);
        case (kind)
            "I": return 32'(s >>> 20);
            "S": return 32'((s >>> 25) << 5) | 32'(w[11:7]);
            "B": return 32'((s >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            "U": return w & 32'hFFFF_F000;
            default: return 32'((s >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        endcase
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs);
`ifdef ID_FORWARD_EN
        if (rs == 0) return 32'h0;
        if (fex_we_i && fex_waddr_i == rs) return fex_wdata_i;
        if (fmem_we_i && fmem_waddr_i == rs) return fmem_wdata_i;
`endif
        return regs[rs];
    endfunction

    function automatic ex_t model_decode();
        ex_t d = '0;
        logic [31:0] w = id_inst_i;
        logic [2:0] f3 = w[14:12];
        logic [31:0] a = operand(w[19:15]);
        logic [31:0] b = operand(w[24:20]);
        d.valid = 1'b1; d.pc = id_pc_i; d.rd = w[11:7]; d.aluop = 5'(ALU_ADD);
        case (w[6:0])
            OP_LUI:    begin d.we = 1; d.imm = imm_of(w, "U"); d.op1 = 0;       d.op2 = d.imm; end
            OP_AUIPC:  begin d.we = 1; d.imm = imm_of(w, "U"); d.op1 = id_pc_i; d.op2 = d.imm; end
            OP_JAL:    begin d.we = 1; d.branch = 1; d.imm = imm_of(w, "J"); d.op1 = id_pc_i; d.op2 = 4; end
            OP_JALR:   begin d.we = 1; d.branch = 1; d.imm = imm_of(w, "I"); d.op1 = id_pc_i; d.op2 = 4; end
            OP_BRANCH: begin d.branch = 1; d.aluop = 5'(br_tab[f3]); d.imm = imm_of(w, "B"); d.op1 = a; d.op2 = b; end
            OP_LOAD:   begin d.we = 1; d.load = 1; d.imm = imm_of(w, "I"); d.op1 = a; d.op2 = d.imm; end
            OP_STORE:  begin d.store = 1; d.imm = imm_of(w, "S"); d.op1 = a; d.op2 = d.imm; end
            OP_IMM: begin
                d.we = 1; d.imm = imm_of(w, "I"); d.op1 = a; d.op2 = d.imm;
                d.aluop = (f3 == 5 && w[30]) ? 5'(ALU_SRA) : 5'(alu_tab[f3]);
            end
            default: begin
                d.we = 1; d.op1 = a; d.op2 = b;
                if (w[30] && f3 == 0)      d.aluop = 5'(ALU_SUB);
                else if (w[30] && f3 == 5) d.aluop = 5'(ALU_SRA);
                else                       d.aluop = 5'(alu_tab[f3]);
            end
        endcase
        return d;
    endfunction

    task automatic model_eval();
        logic [6:0] op = id_inst_i[6:0];
        logic [4:0] r1 = id_inst_i[19:15];
        logic [4:0] r2 = id_inst_i[24:20];
        logic known = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                 OP_LOAD, OP_STORE, OP_IMM, OP_REG};
        logic haz, hit_ex, hit_mem;
        exp_re1 = id_valid_i && (op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG});
        exp_re2 = id_valid_i && (op inside {OP_BRANCH, OP_STORE, OP_REG});
        hit_ex  = fex_we_i && fex_waddr_i != 0 &&
                  ((exp_re1 && fex_waddr_i == r1) || (exp_re2 && fex_waddr_i == r2));
        hit_mem = fmem_we_i && fmem_waddr_i != 0 &&
                  ((exp_re1 && fmem_waddr_i == r1) || (exp_re2 && fmem_waddr_i == r2));
`ifdef ID_FORWARD_EN
        haz = hit_ex && fex_load_i;
`else
        haz = hit_ex || hit_mem;
`endif
        exp_sreq = !rst && !flush_i && (stall_i || haz);
        if (rst || flush_i)              exp_nxt = '0;
        else if (stall_i)                exp_nxt = exp_ex;
        else if (haz || !id_valid_i || !known) exp_nxt = '0;
        else                             exp_nxt = model_decode();
    endtask

    // drive regfile data for the current instruction, let logic settle, predict
    task automatic settle();
        rdata1_i = regs[id_inst_i[19:15]];
        rdata2_i = regs[id_inst_i[24:20]];
        model_eval();
        #1;
    endtask

    task automatic clk_edge();
        @(posedge dclk);
        exp_ex = exp_nxt;
        #1;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] ed, input logic el,
                           input logic mw, input logic [4:0] ma, input logic [31:0] md);
        fex_we_i = ew; fex_waddr_i = ea; fex_wdata_i = ed; fex_load_i = el;
        fmem_we_i = mw; fmem_waddr_i = ma; fmem_wdata_i = md;
    endtask

    task automatic test_reset();
        rst = 1; stall_i = 0; flush_i = 0; id_valid_i = 1; id_pc_i = 32'h100; id_inst_i = ADDI_X1_5;
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            stall_i = (c == 2);
            settle();
            n_checks++;
            if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req c%0d: got %b want 0", c, stall_req_o); end
            clk_edge();
            n_checks++;
            if (dut_ex() !== ex_t'('0)) begin n_fail++; $display("FAIL reset_ex c%0d: got %h want 0", c, dut_ex()); end
        end
        rst = 0; stall_i = 0;
    endtask

    task automatic test_addi();
        id_valid_i = 1; id_pc_i = 32'h200; id_inst_i = ADDI_X1_5;
        settle();
        n_checks++;
        if ({re1_o, re2_o, raddr1_o} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++; $display("FAIL addi_read: got re1=%b re2=%b ra1=%0d want 1 0 0", re1_o, re2_o, raddr1_o);
        end
        clk_edge();
        n_checks++;
        if ({ex_valid_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o} !== {1'b1, 32'd0, 32'd5, 5'd1, 1'b1}) begin
            n_fail++; $display("FAIL addi_fields: got v=%b op1=%h op2=%h rd=%0d we=%b", ex_valid_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o);
        end
        n_checks++;
        if (dut_ex() !== exp_ex) begin n_fail++; $display("FAIL addi_model: got %h want %h", dut_ex(), exp_ex); end
    endtask

    task automatic test_forward();
        regs[1] = 32'h33; regs[2] = 32'h55;
        id_inst_i = ADD_X3_1_2; id_pc_i = 32'h204;
        set_fwd(1, 1, 32'h11, 0, 1, 1, 32'h22);
        settle();
        clk_edge();
`ifdef ID_FORWARD_EN
        n_checks++;
        if (ex_op1_o !== 32'h11) begin n_fail++; $display("FAIL fwd_ex: got %h want 11", ex_op1_o); end
        fex_we_i = 0;
        settle(); clk_edge();
        n_checks++;
        if (ex_op1_o !== 32'h22) begin n_fail++; $display("FAIL fwd_mem: got %h want 22", ex_op1_o); end
`else
        n_checks++;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL nofwd_ex_bubble: got %b want 0", ex_valid_o); end
        fex_we_i = 0;
        settle();
        n_checks++;
        if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL nofwd_mem_stall: got %b want 1", stall_req_o); end
        clk_edge();
        fmem_we_i = 0;
        settle();
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL nofwd_release: got %b want 0", stall_req_o); end
        clk_edge();
        n_checks++;
        if (ex_op1_o !== 32'h33) begin n_fail++; $display("FAIL nofwd_regfile: got %h want 33", ex_op1_o); end
`endif
        n_checks++;
        if (dut_ex() !== exp_ex) begin n_fail++; $display("FAIL forward_model: got %h want %h", dut_ex(), exp_ex); end
    endtask

    task automatic test_load_use();
        id_inst_i = ADD_X3_1_2; id_pc_i = 32'h208;
        set_fwd(1, 1, 32'hDEAD, 1, 0, 0, 0);
        settle();
        n_checks++;
        if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: got %b want 1", stall_req_o); end
        clk_edge();
        n_checks++;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble: got %b want 0", ex_valid_o); end
        set_fwd(0, 0, 0, 0, 1, 1, 32'h44);
        settle();
`ifdef ID_FORWARD_EN
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL loaduse_one_bubble: got %b want 0", stall_req_o); end
        clk_edge();
        n_checks++;
        if (ex_op1_o !== 32'h44) begin n_fail++; $display("FAIL loaduse_memfwd: got %h want 44", ex_op1_o); end
`else
        n_checks++;
        if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL nofwd_load_mem: got %b want 1", stall_req_o); end
        clk_edge();
`endif
        n_checks++;
        if (dut_ex() !== exp_ex) begin n_fail++; $display("FAIL loaduse_model: got %h want %h", dut_ex(), exp_ex); end
    endtask

    task automatic test_flush_stall();
        ex_t held;
        id_inst_i = ADD_X3_1_2; id_pc_i = 32'h20C;
        set_fwd(1, 1, 32'h0, 1, 0, 0, 0);
        flush_i = 1;
        settle();
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_req: got %b want 0", stall_req_o); end
        clk_edge();
        n_checks++;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_valid: got %b want 0", ex_valid_o); end
        flush_i = 0; set_fwd(0, 0, 0, 0, 0, 0, 0);
        id_inst_i = ADDI_X1_5; id_pc_i = 32'h210;
        settle(); clk_edge();
        held = exp_ex;
        n_checks++;
        if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL prestall_valid: got %b want 1", ex_valid_o); end
        stall_i = 1; id_inst_i = ADD_X3_1_2; id_pc_i = 32'h214;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++;
            if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL stall_req c%0d: got %b want 1", c, stall_req_o); end
            clk_edge();
            n_checks++;
            if (dut_ex() !== held) begin n_fail++; $display("FAIL stall_hold c%0d: got %h want %h", c, dut_ex(), held); end
        end
        stall_i = 0;
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                 OP_LOAD, OP_STORE, OP_IMM, OP_REG, 7'b0001111};
        logic [31:0] w;
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            stall_i    = ($urandom_range(0, 9) == 0);
            id_valid_i = ($urandom_range(0, 9) != 0);
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 9)];
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            w[11:7]  = 5'($urandom_range(0, 3));
            id_inst_i = w;
            id_pc_i   = $urandom & 32'hFFFF_FFFC;
            for (int r = 1; r < 4; r++) regs[r] = $urandom;
            set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) == 0),
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            settle();
            n_checks++;
            if (stall_req_o !== exp_sreq) begin n_fail++; $display("FAIL rnd_stall_req n%0d: got %b want %b", n, stall_req_o, exp_sreq); end
            n_checks++;
            if ({re1_o, re2_o} !== {exp_re1, exp_re2}) begin
                n_fail++; $display("FAIL rnd_re n%0d: got %b%b want %b%b", n, re1_o, re2_o, exp_re1, exp_re2);
            end
            n_checks++;
            if ({raddr1_o, raddr2_o} !== {w[19:15], w[24:20]}) begin
                n_fail++; $display("FAIL rnd_raddr n%0d: got %0d %0d want %0d %0d", n, raddr1_o, raddr2_o, w[19:15], w[24:20]);
            end
            clk_edge();
            n_checks++;
            if (dut_ex() !== exp_ex) begin n_fail++; $display("FAIL rnd_ex n%0d: got %h want %h", n, dut_ex(), exp_ex); end
        end
        rst = 0; flush_i = 0; stall_i = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
